// File: rtl/sched_issue_port.sv
// Scheduler-side issue port: a 2-entry in-order buffer between the picker and
// one execution-unit port, with speculative-kill filtering, flush and issue accounting.
module sched_issue_port #(
  parameter int          PORTID      = 0,
  parameter logic [15:0] FU_PRESENT  = 16'h0001,
  parameter int          SPEC_STATES = 8,
  parameter int          PAYLOAD_W   = 128
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                Flush,
  input  logic [SPEC_STATES-1:0]              Spectag_Valid,
  input  logic                                Sel_Valid,
  input  logic [3:0]                          Sel_FuType,
  input  logic [SPEC_STATES-1:0]              Sel_Spectag,
  input  logic [PAYLOAD_W-1:0]                Sel_Payload,
  output logic                                Sel_Ready,
  input  logic [15:0]                         Port_E2S,
  output logic [4+SPEC_STATES+PAYLOAD_W:0]    Port_S2E,
  output logic                                Err_BadFu,
  output logic [15:0]                         Issue_Cnt
);

  localparam int ENT_W = 4 + SPEC_STATES + PAYLOAD_W;

  // An entry is {futype, spectag, payload}; slot 0 is always the head.
  logic [ENT_W-1:0]       ent_q [2];
  logic [ENT_W-1:0]       ent_d [2];
  logic [1:0]             vld_q, vld_d;
  logic [ENT_W:0]         s2e_q, s2e_d;
  logic                   err_q;
  logic [15:0]            cnt_q, cnt_d;

  logic [3:0]             head_fu_s;
  logic [SPEC_STATES-1:0] head_tag_s, tag1_s;
  logic [ENT_W-1:0]       in_s;
  logic                   alive0_s, alive1_s, fu_ok_s, issue_s, bad_s, keep0_s, push_s;

  function automatic logic tag_dead(input logic [SPEC_STATES-1:0] tag,
                                    input logic [SPEC_STATES-1:0] alive);
    return |(tag & ~alive);
  endfunction

  assign Sel_Ready = ~vld_q[1];
  assign Port_S2E  = s2e_q;
  assign Err_BadFu = err_q;
  assign Issue_Cnt = cnt_q;

  // Head decode and issue / bad-FU / push decisions.
  always_comb begin
    head_fu_s  = ent_q[0][ENT_W-1 -: 4];
    head_tag_s = ent_q[0][PAYLOAD_W +: SPEC_STATES];
    tag1_s     = ent_q[1][PAYLOAD_W +: SPEC_STATES];
    in_s       = {Sel_FuType, Sel_Spectag, Sel_Payload};
    alive0_s   = vld_q[0] & ~tag_dead(head_tag_s, Spectag_Valid);
    alive1_s   = vld_q[1] & ~tag_dead(tag1_s, Spectag_Valid);
    fu_ok_s    = FU_PRESENT[head_fu_s];
    issue_s    = alive0_s & fu_ok_s & Port_E2S[head_fu_s] & ~Flush;
    bad_s      = alive0_s & ~fu_ok_s;
    keep0_s    = alive0_s & ~issue_s & ~bad_s;
    push_s     = Sel_Valid & ~vld_q[1] & ~tag_dead(Sel_Spectag, Spectag_Valid) & ~Flush;
  end

  // Survivors compact toward slot 0 in order; the incoming micro-op lands behind them.
  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    vld_d    = 2'b00;
    if (Flush) begin
      vld_d = 2'b00;
    end else if (keep0_s) begin
      vld_d[0] = 1'b1;
      if (alive1_s) begin
        vld_d[1] = 1'b1;
      end else if (push_s) begin
        ent_d[1] = in_s;
        vld_d[1] = 1'b1;
      end else begin
        vld_d[1] = 1'b0;
      end
    end else if (alive1_s) begin
      ent_d[0] = ent_q[1];
      vld_d[0] = 1'b1;
      if (push_s) begin
        ent_d[1] = in_s;
        vld_d[1] = 1'b1;
      end else begin
        vld_d[1] = 1'b0;
      end
    end else if (push_s) begin
      ent_d[0] = in_s;
      vld_d    = 2'b01;
    end else begin
      vld_d = 2'b00;
    end
  end

  // Output stage: valid for exactly one cycle per issue, otherwise cleared.
  always_comb begin
    if (issue_s) begin
      s2e_d = {1'b1, ent_q[0]};
    end else begin
      s2e_d = '0;
    end
    cnt_d = cnt_q + {15'd0, issue_s};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 2'b00;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      s2e_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      vld_q    <= vld_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      s2e_q    <= s2e_d;
      err_q    <= bad_s;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sched_issue_port.sv
// Bench for sched_issue_port: directed table, hand sequences and random stimulus
// against a queue-based reference model.
module tb_sched_issue_port;
  localparam int          SS      = 8;
  localparam int          PW      = 16;
  localparam int          OW      = 1 + 4 + SS + PW;
  localparam logic [15:0] FU_MASK = 16'h0001;

  logic          clk = 1'b0;
  logic          rst, Flush, Sel_Valid, Sel_Ready, Err_BadFu;
  logic [SS-1:0] Spectag_Valid, Sel_Spectag;
  logic [3:0]    Sel_FuType;
  logic [PW-1:0] Sel_Payload;
  logic [15:0]   Port_E2S, Issue_Cnt;
  logic [OW-1:0] Port_S2E;

  always #5 clk = ~clk;

  sched_issue_port #(.PORTID(0), .FU_PRESENT(FU_MASK), .SPEC_STATES(SS), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .Flush(Flush), .Spectag_Valid(Spectag_Valid),
    .Sel_Valid(Sel_Valid), .Sel_FuType(Sel_FuType), .Sel_Spectag(Sel_Spectag),
    .Sel_Payload(Sel_Payload), .Sel_Ready(Sel_Ready), .Port_E2S(Port_E2S),
    .Port_S2E(Port_S2E), .Err_BadFu(Err_BadFu), .Issue_Cnt(Issue_Cnt)
  );

  typedef struct packed {
    logic [3:0]    fu;
    logic [SS-1:0] tag;
    logic [PW-1:0] pl;
  } uop_t;

  typedef struct {
    logic          rst, flush, sel_v;
    logic [3:0]    fu;
    logic [PW-1:0] pl;
    logic [15:0]   e2s;
    logic          exp_ready, exp_v;
    logic [PW-1:0] exp_pl;
    logic [15:0]   exp_cnt;
  } vec_t;

  uop_t        mq[$];
  logic        m_v, m_err;
  uop_t        m_out;
  logic [15:0] m_cnt;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic bit is_dead(input logic [SS-1:0] tag, input logic [SS-1:0] sv);
    return (tag & ~sv) != '0;
  endfunction

  // Reference model: buffer as a queue, rules applied directly per clock edge.
  task automatic model_step();
    uop_t h;
    uop_t keep[$];
    uop_t nu;
    bit   issued, bad, can_push;
    issued = 1'b0;
    bad    = 1'b0;
    if (rst) begin
      mq.delete();
      m_v = 1'b0; m_err = 1'b0; m_cnt = 16'd0;
      return;
    end
    can_push = Sel_Valid && (mq.size() < 2) && !is_dead(Sel_Spectag, Spectag_Valid) && !Flush;
    h = '0;
    if (mq.size() > 0 && !is_dead(mq[0].tag, Spectag_Valid)) begin
      h = mq[0];
      if (!FU_MASK[h.fu]) begin
        bad = 1'b1; void'(mq.pop_front());
      end else if (Port_E2S[h.fu] && !Flush) begin
        issued = 1'b1; void'(mq.pop_front());
      end
    end
    foreach (mq[i]) if (!is_dead(mq[i].tag, Spectag_Valid)) keep.push_back(mq[i]);
    mq = keep;
    if (Flush) mq.delete();
    else if (can_push) begin
      nu.fu = Sel_FuType; nu.tag = Sel_Spectag; nu.pl = Sel_Payload;
      mq.push_back(nu);
    end
    m_v   = issued;
    m_out = h;
    m_err = bad;
    m_cnt = m_cnt + 16'(issued);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("ready", 32'(Sel_Ready), 32'(mq.size() < 2));
    check("valid", 32'(Port_S2E[OW-1]), 32'(m_v));
    if (m_v) begin
      check("fu", 32'(Port_S2E[OW-2 -: 4]), 32'(m_out.fu));
      check("tag", 32'(Port_S2E[PW +: SS]), 32'(m_out.tag));
      check("payload", 32'(Port_S2E[PW-1:0]), 32'(m_out.pl));
    end
    check("err", 32'(Err_BadFu), 32'(m_err));
    check("cnt", 32'(Issue_Cnt), 32'(m_cnt));
  endtask

  task automatic idle();
    rst = 1'b0; Flush = 1'b0; Sel_Valid = 1'b0;
    Spectag_Valid = {SS{1'b1}};
    Sel_FuType = 4'h0; Sel_Spectag = '0; Sel_Payload = '0;
  endtask

  task automatic push(input logic [3:0] fu, input logic [SS-1:0] tag, input logic [PW-1:0] pl);
    Sel_Valid = 1'b1; Sel_FuType = fu; Sel_Spectag = tag; Sel_Payload = pl;
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic sv, input logic [PW-1:0] pl,
                              input logic [15:0] e2s, input logic er, input logic ev,
                              input logic [PW-1:0] epl, input logic [15:0] ec);
    vec_t v;
    v.rst = r; v.flush = f; v.sel_v = sv; v.fu = 4'h0; v.pl = pl; v.e2s = e2s;
    v.exp_ready = er; v.exp_v = ev; v.exp_pl = epl; v.exp_cnt = ec;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    int guard;
    logic [15:0] cnt_before;
    //            rst   flush sel   pl      e2s     rdy   v     pl      cnt
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 16'h00, 16'h0001, 1'b1, 1'b0, 16'h00, 16'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 16'h11, 16'h0001, 1'b1, 1'b0, 16'h00, 16'd0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 16'h00, 16'h0001, 1'b1, 1'b1, 16'h11, 16'd1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 16'h00, 16'h0001, 1'b1, 1'b0, 16'h00, 16'd1);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 16'h21, 16'h0000, 1'b1, 1'b0, 16'h00, 16'd1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 16'h22, 16'h0000, 1'b0, 1'b0, 16'h00, 16'd1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 16'h23, 16'h0000, 1'b0, 1'b0, 16'h00, 16'd1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 16'h23, 16'h0001, 1'b1, 1'b1, 16'h21, 16'd2);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 16'h23, 16'h0001, 1'b1, 1'b1, 16'h22, 16'd3);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 16'h00, 16'h0001, 1'b1, 1'b1, 16'h23, 16'd4);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 16'h00, 16'h0001, 1'b1, 1'b0, 16'h00, 16'd4);

    idle();
    Port_E2S = 16'h0000;
    #2;
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; Flush = tbl[i].flush; Sel_Valid = tbl[i].sel_v;
      Sel_FuType = tbl[i].fu; Sel_Spectag = '0; Sel_Payload = tbl[i].pl;
      Port_E2S = tbl[i].e2s;
      step();
      check($sformatf("tbl%0d_ready", i), 32'(Sel_Ready), 32'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_valid", i), 32'(Port_S2E[OW-1]), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) check($sformatf("tbl%0d_pl", i), 32'(Port_S2E[PW-1:0]), 32'(tbl[i].exp_pl));
      check($sformatf("tbl%0d_cnt", i), 32'(Issue_Cnt), 32'(tbl[i].exp_cnt));
    end

    // Killed head is dropped; only the live younger entry reaches the port.
    idle(); Port_E2S = 16'h0000;
    push(4'h0, 8'h02, 16'h31); step();
    push(4'h0, 8'h00, 16'h32); step();
    idle(); Spectag_Valid = 8'hFD; Port_E2S = 16'h0001; step();
    check("t3_drop_v", 32'(Port_S2E[OW-1]), 32'd0);
    idle(); step();
    check("t3_live_v", 32'(Port_S2E[OW-1]), 32'd1);
    check("t3_live_pl", 32'(Port_S2E[PW-1:0]), 32'h32);

    // Flush with a full buffer and a same-cycle offer.
    idle(); Port_E2S = 16'h0000;
    push(4'h0, 8'h00, 16'h41); step();
    push(4'h0, 8'h00, 16'h42); step();
    cnt_before = m_cnt;
    push(4'h0, 8'h00, 16'h43); Flush = 1'b1; step();
    check("t4_ready", 32'(Sel_Ready), 32'd1);
    check("t4_valid", 32'(Port_S2E[OW-1]), 32'd0);
    check("t4_cnt", 32'(Issue_Cnt), 32'(cnt_before));
    idle(); Port_E2S = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_noissue", 32'(Port_S2E[OW-1]), 32'd0);
    end

    // Absent FU type is dropped with an error pulse; the next entry issues.
    idle(); Port_E2S = 16'hFFFF;
    push(4'h3, 8'h00, 16'h51); step();
    push(4'h0, 8'h00, 16'h52); step();
    check("t5_err", 32'(Err_BadFu), 32'd1);
    check("t5_noissue", 32'(Port_S2E[OW-1]), 32'd0);
    idle(); step();
    check("t5_err_off", 32'(Err_BadFu), 32'd0);
    check("t5_next_pl", 32'(Port_S2E[PW-1:0]), 32'h52);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 127) == 0);
      Flush = ($urandom_range(0, 31) == 0);
      Spectag_Valid = ($urandom_range(0, 7) == 0) ? ~(SS'(1) << $urandom_range(0, SS-1)) : {SS{1'b1}};
      Sel_Valid   = 1'($urandom_range(0, 1));
      Sel_FuType  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      Sel_Spectag = ($urandom_range(0, 3) == 0) ? (SS'(1) << $urandom_range(0, SS-1)) : '0;
      Sel_Payload = PW'($urandom);
      Port_E2S    = 16'($urandom);
      step();
    end

    // Drive the issue counter to its wrap point.
    idle(); Port_E2S = 16'h0001;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      push(4'h0, 8'h00, PW'(guard));
      step();
      guard++;
    end
    check("preload_cnt", 32'(Issue_Cnt), 32'hFFFF);
    idle(); Port_E2S = 16'h0001; step();
    check("wrap_cnt", 32'(Issue_Cnt), 32'h0);

    // Reset mid-stream with an issue pending.
    idle(); Port_E2S = 16'h0000;
    push(4'h0, 8'h00, 16'h61); step();
    push(4'h0, 8'h00, 16'h62); step();
    Port_E2S = 16'h0001; rst = 1'b1; step();
    check("rst_s2e", 32'(Port_S2E), 32'h0);
    check("rst_err", 32'(Err_BadFu), 32'h0);
    check("rst_cnt", 32'(Issue_Cnt), 32'h0);
    check("rst_ready", 32'(Sel_Ready), 32'h1);
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
